fp_cmp_sched: RTL and testbench

//   Round-robin scheduler that shares one 32-bit float greater-than comparator among

---
 rtl/fp_cmp_sched_if.sv | 22 ++
 rtl/fp_cmp_sched.sv | 76 +++++++
 tb/tb_fp_cmp_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_cmp_sched_if.sv
// fp_cmp_sched_if: request/response bundle between requesters and the shared comparator scheduler
interface fp_cmp_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_gt;
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gt
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gt
    );
endinterface

// File: rtl/fp_cmp_sched.sv
// fp_cmp_sched: round-robin scheduler sharing one float greater-than comparator among NREQ requesters
module fp_cmp_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_cmp_sched_if.slave   bus,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
    state_t         state;
    logic [IDW-1:0] rr_ptr, gnt, id_r;
    logic           any, gt;
    logic [31:0]    a_r, b_r, sel_a, sel_b;
    // lowest round-robin offset wins, so scan offsets from highest to lowest
    always_comb begin
        gnt = '0;
        any = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (bus.req_valid[IDW'((int'(rr_ptr) + i) % NREQ)]) begin
                gnt = IDW'((int'(rr_ptr) + i) % NREQ);
                any = 1'b1;
            end
        for (int i = 0; i < NREQ; i++)
            if (gnt == IDW'(i)) begin
                sel_a = bus.req_a[32*i +: 32];
                sel_b = bus.req_b[32*i +: 32];
            end
    end
    assign bus.req_ready = (rst_n && state == IDLE && any) ? NREQ'(1) << gnt : '0;
    // sign-magnitude order without inverting negative pairs, matching the shared comparator
    assign gt = (a_r[31] != b_r[31]) ? ~a_r[31] : (a_r[30:0] > b_r[30:0]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_gt    <= 1'b0;
            busy          <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    a_r    <= sel_a;
                    b_r    <= sel_b;
                    id_r   <= gnt;
                    rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    busy   <= 1'b1;
                    state  <= CMP;
                end
                CMP: begin
                    bus.rsp_gt    <= gt;
                    bus.rsp_id    <= id_r;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    op_count      <= op_count + 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_cmp_sched.sv
// tb_fp_cmp_sched: directed checks of grant order, compare rules, backpressure, reset and counter wrap
module tb_fp_cmp_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [3:0] op_count;
    int         checks = 0;
    int         errors = 0;
    int         exp_cnt = 0;

    fp_cmp_sched_if #(.NREQ(4), .IDW(2)) bus();

    fp_cmp_sched #(.NREQ(4), .IDW(2), .CNTW(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .busy(busy),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        bus.req_valid = '0;
        tick;
        tick;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    // drives one request on a lane and returns the response it produced
    task automatic op(input int lane, input logic [31:0] a, input logic [31:0] b,
                      output logic gt, output logic [1:0] id, output bit ok);
        bus.req_a[32*lane +: 32] = a;
        bus.req_b[32*lane +: 32] = b;
        bus.req_valid = 4'b0001 << lane;
        bus.rsp_ready = 1'b1;
        ok = 0;
        gt = 1'b0;
        id = '0;
        for (int k = 0; k < 10 && !ok; k++) begin
            tick;
            if (bus.rsp_valid) begin
                ok = 1;
                gt = bus.rsp_gt;
                id = bus.rsp_id;
            end
        end
        bus.req_valid = '0;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        tick;
        tick;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); end
        checks++; if (bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL reset_rsp_gt got %b exp 0", bus.rsp_gt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        bus.req_a[31:0] = 32'h4000_0000;
        bus.req_b[31:0] = 32'h3F80_0000;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        bus.req_a[31:0] = 32'h0000_0000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_cmp got %b exp 1", busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", bus.rsp_valid); end
        tick;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id got %0d exp 0", bus.rsp_id); end
        checks++; if (bus.rsp_gt !== 1'b1) begin errors++; $display("FAIL single_rsp_gt got %b exp 1", bus.rsp_gt); end
        tick;
        exp_cnt = 1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_clear got %b exp 0", bus.rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", busy); end
        checks++; if (op_count !== 4'(exp_cnt)) begin errors++; $display("FAIL single_op_count got %0d exp %0d", op_count, exp_cnt); end
    endtask

    task automatic test_compare;
        int          lanes [6] = '{1, 2, 3, 0, 1, 2};
        logic [31:0] va [6] = '{32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
        logic [31:0] vb [6] = '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'hC000_0000, 32'h8000_0000};
        logic        ve [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        gt;
        logic [1:0]  id;
        bit          ok;
        for (int i = 0; i < 6; i++) begin
            op(lanes[i], va[i], vb[i], gt, id, ok);
            exp_cnt++;
            checks++; if (!ok) begin errors++; $display("FAIL cmp_timeout vec %0d got no response exp response", i); end
            checks++; if (gt !== ve[i]) begin errors++; $display("FAIL cmp_gt vec %0d a %h b %h got %b exp %b", i, va[i], vb[i], gt, ve[i]); end
            checks++; if (id !== 2'(lanes[i])) begin errors++; $display("FAIL cmp_id vec %0d got %0d exp %0d", i, id, lanes[i]); end
        end
        checks++; if (op_count !== 4'(exp_cnt)) begin errors++; $display("FAIL cmp_op_count got %0d exp %0d", op_count, exp_cnt); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_ids [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1};
        logic [1:0] ids [8];
        int         cyc [8];
        int         n = 0;
        reset_dut;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b exp 0001", bus.req_ready); end
        for (int k = 0; k < 60 && n < 8; k++) begin
            tick;
            if (bus.rsp_valid) begin
                ids[n] = bus.rsp_id;
                cyc[n] = k;
                n++;
                if (n == 5) bus.req_valid = 4'b1010;
                if (n == 8) bus.req_valid = 4'b0000;
            end
        end
        tick;
        exp_cnt = n;
        checks++; if (n != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (ids[i] !== exp_ids[i]) begin errors++; $display("FAIL rr_order grant %0d got %0d exp %0d", i, ids[i], exp_ids[i]); end
        end
        for (int i = 1; i < n; i++) begin
            checks++; if (cyc[i] - cyc[i-1] != 3) begin errors++; $display("FAIL rr_spacing grant %0d got %0d exp 3", i, cyc[i] - cyc[i-1]); end
        end
        checks++; if (op_count !== 4'd8) begin errors++; $display("FAIL rr_op_count got %0d exp 8", op_count); end
    endtask

    task automatic test_backpressure;
        bus.req_a[95:64] = 32'hC000_0000;
        bus.req_b[95:64] = 32'hBF80_0000;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        tick;
        bus.req_valid = '0;
        tick;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid cyc %0d got %b exp 1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL bp_rsp_id cyc %0d got %0d exp 2", k, bus.rsp_id); end
            checks++; if (bus.rsp_gt !== 1'b1) begin errors++; $display("FAIL bp_rsp_gt cyc %0d got %b exp 1", k, bus.rsp_gt); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy cyc %0d got %b exp 1", k, busy); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready cyc %0d got %b exp 0000", k, bus.req_ready); end
            tick;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick;
        exp_cnt++;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", bus.rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b exp 0", busy); end
        checks++; if (op_count !== 4'(exp_cnt)) begin errors++; $display("FAIL bp_op_count got %0d exp %0d", op_count, exp_cnt); end
        tick;
        checks++; if (op_count !== 4'(exp_cnt)) begin errors++; $display("FAIL bp_op_count_once got %0d exp %0d", op_count, exp_cnt); end
    endtask

    task automatic test_reset_mid;
        bit got = 0;
        bus.req_a[127:96] = 32'h4000_0000;
        bus.req_b[127:96] = 32'h3F80_0000;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1000;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_in_cmp got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_req_ready got %b exp 0000", bus.req_ready); end
        checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL rmid_op_count got %0d exp 0", op_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        tick;
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_held_ready got %b exp 0000", bus.req_ready); end
        tick;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant got %b exp 0001", bus.req_ready); end
        for (int k = 0; k < 10 && !got; k++) begin
            tick;
            if (bus.rsp_valid) begin
                got = 1;
                bus.req_valid = '0;
                checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_rsp_id got %0d exp 0", bus.rsp_id); end
                checks++; if (bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL rmid_rsp_gt got %b exp 0", bus.rsp_gt); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rmid_timeout got no response exp response"); end
        bus.req_valid = '0;
        tick;
    endtask

    task automatic test_wrap;
        logic       gt;
        logic [1:0] id;
        bit         ok;
        int         missing = 0;
        reset_dut;
        for (int i = 0; i < 16; i++) begin
            op(i % 4, 32'h4000_0000 + i, 32'h3F80_0000, gt, id, ok);
            if (!ok) missing++;
            if (i == 14) begin
                checks++; if (op_count !== 4'd15) begin errors++; $display("FAIL wrap_15 got %0d exp 15", op_count); end
            end
        end
        checks++; if (missing != 0) begin errors++; $display("FAIL wrap_responses got %0d missing exp 0", missing); end
        checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", op_count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_compare;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
